// File: rtl/dac_spi_tx_pkg.sv
// Shared constants, FSM encoding and sample-to-code conversion for the DAC serial transmitter.
// Build option: DAC_SAT_EN clamps samples to the 12-bit range instead of wrapping.
package dac_spi_tx_pkg;

   localparam int FRAME_W = 16;
   localparam int DATA_W  = 12;
   localparam logic [DATA_W-1:0] OFFSET = 12'h800;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      SYNC_HI = 2'd2
   } state_t;

   // Inverse of the ADC receiver's sign conversion: two's complement -> offset binary.
   function automatic logic [DATA_W-1:0] sample_to_code(input logic signed [15:0] s);
      logic [DATA_W-1:0] d12;
`ifdef DAC_SAT_EN
      if (s > 16'sd2047)
         d12 = 12'h7FF;
      else if (s < -16'sd2048)
         d12 = 12'h800;
      else
         d12 = s[DATA_W-1:0];
`else
      d12 = s[DATA_W-1:0];
`endif
      return d12 ^ OFFSET;
   endfunction

endpackage

// File: rtl/dac_spi_tx_clk_div.sv
// SCLK generator: CLK_DIV-cycle phase down-counter with rise/fall strobes.
// Clear parks SCLK high and preloads the counter so the first fall lands CLK_DIV cycles later.
module dac_clk_div #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic en_i,
   input  logic clr_i,
   output logic sclk_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LOAD = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic          sclk_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         sclk_q <= 1'b1;
      end else if (clr_i) begin
         cnt_q  <= LOAD;
         sclk_q <= 1'b1;
      end else if (en_i) begin
         if (cnt_q == '0) begin
            cnt_q  <= LOAD;
            sclk_q <= ~sclk_q;
         end else begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   assign fall_o = en_i && (cnt_q == '0) && sclk_q;
   assign rise_o = en_i && (cnt_q == '0) && !sclk_q;
   assign sclk_o = sclk_q;

endmodule

// File: rtl/dac_spi_tx.sv
// Three-wire serial transmitter for the 12-bit audio DAC: one 16-bit frame per accepted sample.
// Build option: DAC_SAT_EN (see dac_spi_tx_pkg) selects saturation instead of wrap.
//
// state   | meaning
// IDLE    | listo high, SYNC/SCLK high, waiting for dato_valido
// SHIFT   | SYNC low, 16 SCLK periods, DIN updated on SCLK rising edges
// SYNC_HI | SYNC held high SYNC_HIGH cycles before the next accept
module dac_spi_tx
   import dac_spi_tx_pkg::*;
#(
   parameter int         CLK_DIV   = 2,
   parameter int         SYNC_HIGH = 2,
   parameter logic [1:0] PD_MODE   = 2'b00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] d_in,
   input  logic        dato_valido,
   output logic        listo,
   output logic        fin,
   output logic        sync,
   output logic        sclk,
   output logic        dout
);

   localparam int HW = (SYNC_HIGH > 1) ? $clog2(SYNC_HIGH) : 1;

   state_t               state_q;
   logic [FRAME_W-1:0]   shreg_q;
   logic [4:0]           nfall_q;
   logic [HW-1:0]        hold_q;
   logic                 listo_q, fin_q, sync_q, dout_q;
   logic [FRAME_W-1:0]   frame_d;
   logic                 rise, fall;

   assign frame_d = {2'b00, PD_MODE, sample_to_code(d_in)};

   dac_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
      .clk    (clk),
      .reset  (reset),
      .en_i   (state_q == SHIFT),
      .clr_i  (state_q == IDLE),
      .sclk_o (sclk),
      .rise_o (rise),
      .fall_o (fall)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         shreg_q <= '0;
         nfall_q <= '0;
         hold_q  <= '0;
         listo_q <= 1'b1;
         fin_q   <= 1'b0;
         sync_q  <= 1'b1;
         dout_q  <= 1'b0;
      end else begin
         fin_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (dato_valido) begin
                  state_q <= SHIFT;
                  dout_q  <= frame_d[FRAME_W-1];
                  shreg_q <= {frame_d[FRAME_W-2:0], 1'b0};
                  nfall_q <= '0;
                  sync_q  <= 1'b0;
                  listo_q <= 1'b0;
               end
            end
            SHIFT: begin
               if (fall)
                  nfall_q <= nfall_q + 1'b1;
               // The rise after the 16th fall closes the frame instead of shifting.
               if (rise) begin
                  if (nfall_q == 5'd16) begin
                     state_q <= SYNC_HI;
                     sync_q  <= 1'b1;
                     dout_q  <= 1'b0;
                     hold_q  <= HW'(SYNC_HIGH - 1);
                  end else begin
                     dout_q  <= shreg_q[FRAME_W-1];
                     shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
                  end
               end
            end
            SYNC_HI: begin
               if (hold_q == '0) begin
                  state_q <= IDLE;
                  listo_q <= 1'b1;
                  fin_q   <= 1'b1;
               end else begin
                  hold_q <= hold_q - 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign listo = listo_q;
   assign fin   = fin_q;
   assign sync  = sync_q;
   assign dout  = dout_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: three instances (CLK_DIV 2/1/5), each with a DAC-side capture model
// and an expected-frame queue filled at accept time.
module tb_dac_spi_tx;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] d_in [3];
   logic        vld  [3];
   logic        listo[3], fin[3], sync[3], sclk[3], dout[3];

   int n_chk = 0, n_bad = 0, cyc = 0;
   int frames[3]  = '{0, 0, 0};
   int aborts[3]  = '{0, 0, 0};
   int last_hi[3] = '{0, 0, 0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_frame(input logic [1:0] pd, input logic [15:0] s);
      logic [11:0] d;
      int v;
      d = s[11:0];
      v = $signed(s);
`ifdef DAC_SAT_EN
      if (v > 2047) d = 12'h7FF;
      else if (v < -2048) d = 12'h800;
`endif
      return {2'b00, pd, d ^ 12'h800};
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int         DIV = (g == 1) ? 1 : ((g == 2) ? 5 : 2);
      localparam int         SH  = (g == 2) ? 3 : ((g == 1) ? 1 : 2);
      localparam logic [1:0] PD  = (g == 1) ? 2'b11 : 2'b00;

      dac_spi_tx #(.CLK_DIV(DIV), .SYNC_HIGH(SH), .PD_MODE(PD)) u_dut (
         .clk         (clk),
         .reset       (reset),
         .d_in        (d_in[g]),
         .dato_valido (vld[g]),
         .listo       (listo[g]),
         .fin         (fin[g]),
         .sync        (sync[g]),
         .sclk        (sclk[g]),
         .dout        (dout[g])
      );

      logic        p_sclk = 1'b1, p_sync = 1'b1, p_dout = 1'b0;
      logic        p_listo = 1'b1, p_vld = 1'b0, p_fin = 1'b0;
      logic [15:0] p_din = '0, cap = '0, ef = '0;
      logic [15:0] exp_q[$];
      int nf = 0, since_dout = 0, since_fall = 0, hi_run = 0, acc_cyc = -1;

      always @(negedge clk) begin
         if (p_listo && p_vld && !listo[g]) begin
            ef = exp_frame(PD, p_din);
            exp_q.push_back(ef);
            acc_cyc = cyc;
            chk($sformatf("acc_sync%0d", g), sync[g], 1'b0);
            chk($sformatf("acc_dout%0d", g), dout[g], ef[15]);
         end
         if (!sync[g] && p_sync) begin
            nf = 0;
            since_fall = 0;
         end
         if (sync[g]) hi_run++;
         else if (p_sync) begin
            last_hi[g] = hi_run;
            hi_run = 0;
         end
         if (dout[g] !== p_dout) since_dout = 0;
         else since_dout++;
         since_fall++;
         if (p_sclk && !sclk[g] && !sync[g]) begin
            chk($sformatf("setup%0d", g), since_dout >= DIV, 1);
            if (nf > 0) chk($sformatf("sclk_period%0d", g), since_fall, 2 * DIV);
            since_fall = 0;
            cap = {cap[14:0], dout[g]};
            nf++;
         end
         if (sync[g] && !p_sync) begin
            if (nf == 16) begin
               chk($sformatf("frame_avail%0d", g), exp_q.size() > 0, 1);
               if (exp_q.size() > 0) chk($sformatf("frame%0d", g), cap, exp_q.pop_front());
               frames[g]++;
            end else begin
               aborts[g]++;
               if (exp_q.size() > 0) void'(exp_q.pop_front());
               acc_cyc = -1;
            end
         end
         if (fin[g]) begin
            chk($sformatf("fin_lat%0d", g), cyc - acc_cyc, 32 * DIV + SH);
            chk($sformatf("listo_at_fin%0d", g), listo[g], 1'b1);
         end
         if (p_fin) chk($sformatf("fin_pulse%0d", g), fin[g], 1'b0);
         p_sclk  = sclk[g];
         p_sync  = sync[g];
         p_dout  = dout[g];
         p_listo = listo[g];
         p_vld   = vld[g];
         p_fin   = fin[g];
         p_din   = d_in[g];
      end
   end

   task automatic wait_listo(input int g);
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!listo[g] && n < 1000);
      chk($sformatf("listo_wait%0d", g), listo[g], 1'b1);
   endtask

   task automatic send(input int g, input logic [15:0] v);
      wait_listo(g);
      d_in[g] = v;
      vld[g]  = 1'b1;
      @(posedge clk); #1;
      vld[g]  = 1'b0;
      d_in[g] = 16'hA5A5;
   endtask

   task automatic wait_frames(input int g, input int n);
      int k = 0;
      while (frames[g] < n && k < 1000) begin
         @(posedge clk); #1;
         k++;
      end
      chk($sformatf("frames%0d", g), frames[g], n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, ab;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         d_in[i] = '0;
         vld[i]  = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_sync%0d", i), sync[i], 1'b1);
         chk($sformatf("rst_sclk%0d", i), sclk[i], 1'b1);
         chk($sformatf("rst_dout%0d", i), dout[i], 1'b0);
         chk($sformatf("rst_listo%0d", i), listo[i], 1'b1);
         chk($sformatf("rst_fin%0d", i), fin[i], 1'b0);
      end

      send(0, 16'h0000); wait_frames(0, 1);
      send(0, 16'hF800); wait_frames(0, 2);
      send(0, 16'h07FF); wait_frames(0, 3);
      send(0, 16'h1234); wait_frames(0, 4);
      send(0, 16'h8000); wait_frames(0, 5);

      // back-to-back with dato_valido held high; d_in changes during SHIFT must be ignored
      base = frames[0];
      wait_listo(0);
      d_in[0] = 16'h0100;
      vld[0]  = 1'b1;
      @(posedge clk); #1;
      d_in[0] = 16'h7777;
      repeat (40) @(posedge clk);
      #1 d_in[0] = 16'hFF00;
      wait_listo(0);
      @(posedge clk); #1;
      vld[0]  = 1'b0;
      d_in[0] = 16'h5A5A;
      wait_frames(0, base + 2);
      repeat (200) @(posedge clk);
      #1;
      chk("b2b_count", frames[0], base + 2);
      chk("b2b_sync_hi", last_hi[0], 3);

      // reset at T+20 aborts the frame
      ab = aborts[0];
      base = frames[0];
      send(0, 16'h0123);
      repeat (19) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      chk("abort_sync", sync[0], 1'b1);
      chk("abort_sclk", sclk[0], 1'b1);
      chk("abort_dout", dout[0], 1'b0);
      chk("abort_listo", listo[0], 1'b1);
      chk("abort_fin", fin[0], 1'b0);
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("abort_seen", aborts[0], ab + 1);
      chk("abort_no_frame", frames[0], base);
      send(0, 16'h0000); wait_frames(0, base + 1);

      send(1, 16'h0000); wait_frames(1, 1);
      send(1, 16'h07FF); wait_frames(1, 2);
      send(1, 16'h8000); wait_frames(1, 3);

      send(2, 16'h1234); wait_frames(2, 1);
      send(2, 16'hF800); wait_frames(2, 2);

      repeat (10) @(posedge clk);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
